// File: rtl/apb3_master_if.sv
// apb3_master_if: bundles the command stream, response stream and APB3 bus of apb3_master
//   cmd_*   : valid/ready command stream (write flag, address, write data)
//   rsp_*   : valid/ready response stream (read data, slave error, watchdog abort)
//   P*      : APB3 requester signals towards the responder
//   modport master : view of the initiator (apb3_master)
//   modport slave  : view of everything around it (command source, response sink, APB responder)
interface apb3_master_if #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32
);
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic                  cmd_write;
    logic [ADDR_WIDTH-1:0] cmd_addr;
    logic [DATA_WIDTH-1:0] cmd_wdata;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [DATA_WIDTH-1:0] rsp_rdata;
    logic                  rsp_slverr;
    logic                  rsp_timeout;
    logic [ADDR_WIDTH-1:0] PADDR;
    logic                  PSEL;
    logic                  PENABLE;
    logic                  PWRITE;
    logic [DATA_WIDTH-1:0] PWDATA;
    logic                  PREADY;
    logic [DATA_WIDTH-1:0] PRDATA;
    logic                  PSLVERROR;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready, PREADY, PRDATA, PSLVERROR,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_slverr, rsp_timeout,
               PADDR, PSEL, PENABLE, PWRITE, PWDATA
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready, PREADY, PRDATA, PSLVERROR,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_slverr, rsp_timeout,
               PADDR, PSEL, PENABLE, PWRITE, PWDATA
    );
endinterface

// File: rtl/apb3_master.sv
// apb3_master: single-outstanding APB3 initiator turning a valid/ready command stream into
// SETUP/ACCESS transfers and returning each result on a valid/ready response stream.
//   clk    : sole clock, rising edge
//   resetn : asynchronous, active-low reset
//   bus    : apb3_master_if.master (cmd_* in, rsp_* out, APB3 requester signals)
// Optional watchdog: define APB3_MASTER_TIMEOUT_EN to abort ACCESS after TIMEOUT PREADY-low
// cycles; without it ACCESS waits indefinitely and rsp_timeout is tied low.
module apb3_master #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 255
) (
    input  logic          clk,
    input  logic          resetn,
    apb3_master_if.master bus
);
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SETUP  = 2'd1;
    localparam logic [1:0] ACCESS = 2'd2;
    localparam logic [1:0] RESP   = 2'd3;

    if (TIMEOUT < 1) begin : g_timeout_check
        $error("apb3_master: TIMEOUT must be at least 1");
    end

    logic [1:0] state;
    logic [1:0] state_n;
    logic       accept;
    logic       done;
    logic       abort;

    // A new command can ride on the response handshake so back-to-back transfers skip IDLE.
    assign bus.cmd_ready = (state == IDLE) || (state == RESP && bus.rsp_ready);
    assign accept        = bus.cmd_valid && bus.cmd_ready;
    assign done          = (state == ACCESS) && bus.PREADY;

    // Bus strobes decode straight from the state register so reset drops them at once.
    assign bus.PSEL      = (state == SETUP) || (state == ACCESS);
    assign bus.PENABLE   = (state == ACCESS);
    assign bus.rsp_valid = (state == RESP);

`ifdef APB3_MASTER_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] wait_cnt;
    logic          timeout_q;

    // The abort fires in the wait cycle that would bring the count to TIMEOUT;
    // a PREADY in that same cycle completes normally instead.
    assign abort           = (state == ACCESS) && !bus.PREADY && (wait_cnt == CW'(TIMEOUT - 1));
    assign bus.rsp_timeout = timeout_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wait_cnt  <= '0;
            timeout_q <= 1'b0;
        end else begin
            if (state == SETUP)
                wait_cnt <= '0;
            else if (state == ACCESS && !bus.PREADY)
                wait_cnt <= wait_cnt + 1'b1;
            if (done)
                timeout_q <= 1'b0;
            else if (abort)
                timeout_q <= 1'b1;
        end
    end
`else
    assign abort           = 1'b0;
    assign bus.rsp_timeout = 1'b0;
`endif

    always_comb begin
        state_n = (state == IDLE)   ? (accept ? SETUP : IDLE) :
                  (state == SETUP)  ? ACCESS :
                  (state == ACCESS) ? ((done || abort) ? RESP : ACCESS) :
                  accept            ? SETUP :
                  bus.rsp_ready     ? IDLE : RESP;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state          <= IDLE;
            bus.PADDR      <= '0;
            bus.PWRITE     <= 1'b0;
            bus.PWDATA     <= '0;
            bus.rsp_rdata  <= '0;
            bus.rsp_slverr <= 1'b0;
        end else begin
            state <= state_n;
            if (accept) begin
                bus.PADDR  <= bus.cmd_addr;
                bus.PWRITE <= bus.cmd_write;
                bus.PWDATA <= bus.cmd_wdata;
            end
            if (done) begin
                bus.rsp_rdata  <= bus.PWRITE ? '0 : bus.PRDATA;
                bus.rsp_slverr <= bus.PSLVERROR;
            end else if (abort) begin
                bus.rsp_rdata  <= '0;
                bus.rsp_slverr <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_apb3_master.sv
// tb_apb3_master: directed bench for apb3_master with a transaction-level reference model
// and a scripted APB responder whose wait count, error flag and read data the bench chooses.
//   Responder read data: 0x12345678 at 0x0010, otherwise {~addr, addr}.
//   Build with APB3_MASTER_TIMEOUT_EN to exercise the watchdog (TIMEOUT=8).
module tb_apb3_master;
    localparam int AW = 16;
    localparam int DW = 32;
    localparam int TO = 8;
`ifdef APB3_MASTER_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    apb3_master_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    apb3_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
        .clk(clk),
        .resetn(resetn),
        .bus(bus)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] rd_val(input logic [15:0] a);
        return (a == 16'h0010) ? 32'h12345678 : {~a, a};
    endfunction

    // Reference model: one transfer in APB phase (m_busy, m_age cycles since acceptance)
    // and a queue of responses waiting to be handed over.
    typedef struct packed {
        logic [31:0] rdata;
        logic        slverr;
        logic        tmo;
    } rsp_t;

    rsp_t        m_rsp[$];
    bit          m_busy = 1'b0;
    bit          m_rdy;
    int          m_age = 0;
    int          m_waits = 0;
    logic        m_w = 1'b0;
    logic [15:0] m_a = '0;
    logic [31:0] m_d = '0;
    int          waits_cfg = 0;

    // Responder: PREADY rises once the requested number of wait cycles in ACCESS has passed.
    assign bus.PREADY = m_busy && (m_age >= 2) && ((m_age - 2) >= m_waits);
    assign bus.PRDATA = rd_val(bus.PADDR);

    // Inputs as seen by the DUT at each rising edge.
    logic        s_ok;
    logic        s_cv;
    logic        s_rr;
    logic        s_w;
    logic        s_perr;
    logic [15:0] s_a;
    logic [31:0] s_d;
    int          s_waits;

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            s_ok <= 1'b0;
        end else begin
            s_ok    <= 1'b1;
            s_cv    <= bus.cmd_valid;
            s_rr    <= bus.rsp_ready;
            s_w     <= bus.cmd_write;
            s_a     <= bus.cmd_addr;
            s_d     <= bus.cmd_wdata;
            s_perr  <= bus.PSLVERROR;
            s_waits <= waits_cfg;
        end
    end

    // Advance the model by the edge just taken, then compare every output.
    always @(negedge clk) begin
        if (!resetn) begin
            m_busy = 1'b0;
            m_age  = 0;
            m_w    = 1'b0;
            m_a    = '0;
            m_d    = '0;
            m_rsp.delete();
        end else if (s_ok) begin
            if (m_busy) begin
                if (m_age >= 2 && (m_age - 2) >= m_waits) begin
                    m_rsp.push_back({(m_w ? 32'h0 : rd_val(m_a)), s_perr, 1'b0});
                    m_busy = 1'b0;
                end else if (TO_EN && m_age >= 2 && (m_age - 2) == TO - 1) begin
                    m_rsp.push_back({32'h0, 1'b1, 1'b1});
                    m_busy = 1'b0;
                end else begin
                    m_age++;
                end
            end else begin
                m_rdy = (m_rsp.size() == 0) || s_rr;
                if (m_rsp.size() != 0 && s_rr)
                    void'(m_rsp.pop_front());
                if (m_rdy && s_cv) begin
                    m_busy  = 1'b1;
                    m_age   = 1;
                    m_w     = s_w;
                    m_a     = s_a;
                    m_d     = s_d;
                    m_waits = s_waits;
                end
            end
            chk("psel", bus.PSEL, m_busy);
            chk("penable", bus.PENABLE, m_busy && m_age >= 2);
            chk("cmd_ready", bus.cmd_ready, !m_busy && (m_rsp.size() == 0 || bus.rsp_ready));
            chk("rsp_valid", bus.rsp_valid, m_rsp.size() != 0);
            chk("paddr", bus.PADDR, m_a);
            chk("pwrite", bus.PWRITE, m_w);
            chk("pwdata", bus.PWDATA, m_d);
            if (m_rsp.size() != 0) begin
                chk("rsp_rdata", bus.rsp_rdata, m_rsp[0].rdata);
                chk("rsp_slverr", bus.rsp_slverr, m_rsp[0].slverr);
                chk("rsp_timeout", bus.rsp_timeout, m_rsp[0].tmo);
            end
        end
    end

    // Response handshake log for the back-to-back spacing check.
    int          cyc = 0;
    int          hs_t[$];
    logic [31:0] hs_d[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (resetn && bus.rsp_valid && bus.rsp_ready) begin
            hs_t.push_back(cyc);
            hs_d.push_back(bus.rsp_rdata);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic w, input logic [15:0] a, input logic [31:0] d,
                        input int waits, input logic perr);
        bus.cmd_valid = 1'b1;
        bus.cmd_write = w;
        bus.cmd_addr  = a;
        bus.cmd_wdata = d;
        bus.PSLVERROR = perr;
        waits_cfg     = waits;
        @(negedge clk);
        for (int i = 0; i < 100 && !bus.cmd_ready; i++) @(negedge clk);
        chk("cmd_accept", bus.cmd_ready, 1'b1);
        step();
        bus.cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(output int lat, output int ps, output int pe);
        lat = 0;
        ps  = 0;
        pe  = 0;
        do begin
            @(negedge clk);
            lat++;
            ps += int'(bus.PSEL);
            pe += int'(bus.PENABLE);
        end while (!bus.rsp_valid && lat < 5000);
        chk("rsp_arrives", bus.rsp_valid, 1'b1);
    endtask

    initial begin
        int lat, ps, pe;
        bus.cmd_valid = 1'b0;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = '0;
        bus.cmd_wdata = '0;
        bus.rsp_ready = 1'b1;
        bus.PSLVERROR = 1'b0;
        #2;
        chk("rst_psel", bus.PSEL, 1'b0);
        chk("rst_penable", bus.PENABLE, 1'b0);
        chk("rst_pwrite", bus.PWRITE, 1'b0);
        chk("rst_paddr", bus.PADDR, 16'h0);
        chk("rst_pwdata", bus.PWDATA, 32'h0);
        chk("rst_rsp_valid", bus.rsp_valid, 1'b0);
        chk("rst_rsp_rdata", bus.rsp_rdata, 32'h0);
        chk("rst_rsp_slverr", bus.rsp_slverr, 1'b0);
        chk("rst_rsp_timeout", bus.rsp_timeout, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        resetn = 1'b1;
        @(negedge clk);
        chk("cmd_ready_after_reset", bus.cmd_ready, 1'b1);
        step();

        // Zero-wait write
        send(1'b1, 16'h0004, 32'hDEADBEEF, 0, 1'b0);
        wait_rsp(lat, ps, pe);
        chk("zw_latency", lat, 3);
        chk("zw_psel_cycles", ps, 2);
        chk("zw_penable_cycles", pe, 1);
        chk("zw_rdata", bus.rsp_rdata, 32'h0);
        chk("zw_slverr", bus.rsp_slverr, 1'b0);
        step();

        // Read with five wait states
        send(1'b0, 16'h0010, 32'h0, 5, 1'b0);
        wait_rsp(lat, ps, pe);
        chk("ws_latency", lat, 8);
        chk("ws_access_cycles", pe, 6);
        chk("ws_rdata", bus.rsp_rdata, 32'h12345678);
        chk("ws_paddr", bus.PADDR, 16'h0010);
        step();

        // Slave error with response backpressure
        bus.rsp_ready = 1'b0;
        send(1'b0, 16'h0020, 32'h0, 2, 1'b1);
        wait_rsp(lat, ps, pe);
        for (int i = 0; i < 4; i++) begin
            if (i > 0) @(negedge clk);
            chk("bp_rsp_valid", bus.rsp_valid, 1'b1);
            chk("bp_slverr", bus.rsp_slverr, 1'b1);
            chk("bp_cmd_ready", bus.cmd_ready, 1'b0);
            step();
            bus.PSLVERROR = 1'b0;
        end
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        chk("bp_cmd_ready_release", bus.cmd_ready, 1'b1);
        step();

        // Back-to-back reads
        hs_t.delete();
        hs_d.delete();
        for (int k = 0; k < 3; k++) send(1'b0, 16'h0100 + k[15:0], 32'h0, 0, 1'b0);
        wait_rsp(lat, ps, pe);
        step();
        chk("b2b_count", hs_t.size(), 3);
        chk("b2b_gap01", hs_t[1] - hs_t[0], 3);
        chk("b2b_gap12", hs_t[2] - hs_t[1], 3);
        chk("b2b_data0", hs_d[0], 32'hFEFF0100);
        chk("b2b_data1", hs_d[1], 32'hFEFE0101);
        chk("b2b_data2", hs_d[2], 32'hFEFD0102);

`ifdef APB3_MASTER_TIMEOUT_EN
        // Watchdog abort with a responder that never answers
        send(1'b0, 16'h0040, 32'h0, 100000, 1'b0);
        wait_rsp(lat, ps, pe);
        chk("to_latency", lat, 10);
        chk("to_access_cycles", pe, 8);
        chk("to_rdata", bus.rsp_rdata, 32'h0);
        chk("to_slverr", bus.rsp_slverr, 1'b1);
        chk("to_timeout", bus.rsp_timeout, 1'b1);
        chk("to_psel_dropped", bus.PSEL, 1'b0);
        step();
        send(1'b0, 16'h0050, 32'h0, 100000, 1'b0);
        repeat (3) @(negedge clk);
`else
        send(1'b0, 16'h0050, 32'h0, 100000, 1'b0);
        repeat (1000) @(negedge clk);
        chk("psel_held_1000", bus.PSEL, 1'b1);
`endif
        chk("mid_penable", bus.PENABLE, 1'b1);

        // Reset in the middle of ACCESS
        step();
        resetn = 1'b0;
        #2;
        chk("mr_psel", bus.PSEL, 1'b0);
        chk("mr_penable", bus.PENABLE, 1'b0);
        chk("mr_rsp_valid", bus.rsp_valid, 1'b0);
        step();
        resetn = 1'b1;
        @(negedge clk);
        chk("mr_cmd_ready", bus.cmd_ready, 1'b1);
        step();
        send(1'b1, 16'h0060, 32'h55AA55AA, 1, 1'b0);
        wait_rsp(lat, ps, pe);
        chk("mr_latency", lat, 4);
        chk("mr_rdata", bus.rsp_rdata, 32'h0);
        chk("mr_slverr", bus.rsp_slverr, 1'b0);
        step();
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end
endmodule
